// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: shares one single-port SRAM between scanout and draw ports.
// Priority follows vblank, with a starvation escape for draw and a fixed 2-cycle read return.
module fb_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          vblank,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_gnt,
  output logic          scan_rvalid,
  output logic [DW-1:0] scan_rdata,
  input  logic          draw_req,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wdata,
  output logic          draw_gnt,
  output logic          draw_rvalid,
  output logic [DW-1:0] draw_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    SCAN_PRI   = 2'd0,
    DRAW_PRI   = 2'd1,
    FORCE_DRAW = 2'd2
  } mode_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  mode_e         mode_q, mode_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          tag1_vld_q, tag1_vld_d;
  logic          tag1_draw_q, tag1_draw_d;
  logic          tag2_vld_q, tag2_vld_d;
  logic          tag2_draw_q, tag2_draw_d;
  logic [DW-1:0] scan_rdata_q, scan_rdata_d;
  logic [DW-1:0] draw_rdata_q, draw_rdata_d;
  logic          scan_win;
  logic          draw_win;

  // Grant decision for the current cycle; both grants are suppressed while reset is held.
  always_comb begin
    scan_win = 1'b0;
    draw_win = 1'b0;
    if (!RESET_N) begin
      scan_win = 1'b0;
      draw_win = 1'b0;
    end else begin
      case (mode_q)
        SCAN_PRI: begin
          scan_win = scan_req;
          draw_win = draw_req & ~scan_req;
        end
        DRAW_PRI, FORCE_DRAW: begin
          draw_win = draw_req;
          scan_win = scan_req & ~draw_req;
        end
        default: begin
          scan_win = 1'b0;
          draw_win = 1'b0;
        end
      endcase
    end
  end

  assign scan_gnt = scan_win;
  assign draw_gnt = draw_win;

  // Starvation counter and arbitration mode; a due forced draw beats leaving DRAW_PRI.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    mode_d     = mode_q;
    if (!draw_req || draw_win) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    case (mode_q)
      SCAN_PRI: begin
        if (wait_cnt_q == MAX_WAIT_C) begin
          mode_d = FORCE_DRAW;
        end else if (vblank) begin
          mode_d = DRAW_PRI;
        end else begin
          mode_d = SCAN_PRI;
        end
      end
      DRAW_PRI: begin
        if (vblank) begin
          mode_d = DRAW_PRI;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          mode_d = FORCE_DRAW;
        end else begin
          mode_d = SCAN_PRI;
        end
      end
      FORCE_DRAW: begin
        if (vblank) begin
          mode_d = DRAW_PRI;
        end else begin
          mode_d = SCAN_PRI;
        end
      end
      default: mode_d = SCAN_PRI;
    endcase
  end

  // SRAM command for the winner, plus the owner/read tag that follows it down the pipe.
  always_comb begin
    mem_en_d    = scan_win | draw_win;
    mem_we_d    = draw_win & draw_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (draw_win) begin
      mem_addr_d = draw_addr;
    end else if (scan_win) begin
      mem_addr_d = scan_addr;
    end else begin
      mem_addr_d = mem_addr_q;
    end
    if (draw_win && draw_we) begin
      mem_wdata_d = draw_wdata;
    end else begin
      mem_wdata_d = mem_wdata_q;
    end
    tag1_vld_d  = scan_win | (draw_win & ~draw_we);
    tag1_draw_d = draw_win;
    tag2_vld_d  = tag1_vld_q;
    tag2_draw_d = tag1_draw_q;
  end

  // Read return: SRAM data passes straight through when the tag matures, else last value held.
  always_comb begin
    scan_rvalid  = tag2_vld_q & ~tag2_draw_q;
    draw_rvalid  = tag2_vld_q & tag2_draw_q;
    scan_rdata_d = scan_rdata_q;
    draw_rdata_d = draw_rdata_q;
    if (scan_rvalid) begin
      scan_rdata_d = mem_rdata;
    end else begin
      scan_rdata_d = scan_rdata_q;
    end
    if (draw_rvalid) begin
      draw_rdata_d = mem_rdata;
    end else begin
      draw_rdata_d = draw_rdata_q;
    end
    scan_rdata = scan_rdata_d;
    draw_rdata = draw_rdata_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      mode_q       <= SCAN_PRI;
      wait_cnt_q   <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      tag1_vld_q   <= 1'b0;
      tag1_draw_q  <= 1'b0;
      tag2_vld_q   <= 1'b0;
      tag2_draw_q  <= 1'b0;
      scan_rdata_q <= {DW{1'b0}};
      draw_rdata_q <= {DW{1'b0}};
    end else begin
      mode_q       <= mode_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag1_vld_q   <= tag1_vld_d;
      tag1_draw_q  <= tag1_draw_d;
      tag2_vld_q   <= tag2_vld_d;
      tag2_draw_q  <= tag2_draw_d;
      scan_rdata_q <= scan_rdata_d;
      draw_rdata_q <= draw_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: hand-computed expectations, SRAM model returns addr[7:0]^0x4A.
module tb_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic          vblank;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_gnt;
  logic          scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          draw_req;
  logic          draw_we;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_wdata;
  logic          draw_gnt;
  logic          draw_rvalid;
  logic [DW-1:0] draw_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  fb_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .vblank(vblank),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr),
    .draw_wdata(draw_wdata), .draw_gnt(draw_gnt),
    .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // SRAM model: one-cycle read latency, junk data on cycles without a read.
  always @(posedge CLOCK_50) begin
    if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= mem_addr[7:0] ^ 8'h4A;
    else                                    mem_rdata <= 8'hEE;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic mid;
    @(negedge CLOCK_50);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; vblank = 1'b0;
    scan_req = 1'b0; scan_addr = 19'h0;
    draw_req = 1'b0; draw_we = 1'b0; draw_addr = 19'h0; draw_wdata = 8'h00;
    repeat (3) @(posedge CLOCK_50);
    #1;
    // Reset state, grants held low even with requests pending
    scan_req = 1'b1; draw_req = 1'b1;
    mid;
    check_eq("rst_scan_gnt", 32'(scan_gnt), 32'd0);
    check_eq("rst_draw_gnt", 32'(draw_gnt), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_scan_rvalid", 32'(scan_rvalid), 32'd0);
    check_eq("rst_draw_rvalid", 32'(draw_rvalid), 32'd0);
    check_eq("rst_scan_rdata", 32'(scan_rdata), 32'd0);
    check_eq("rst_draw_rdata", 32'(draw_rdata), 32'd0);
    next_cycle;
    scan_req = 1'b0; draw_req = 1'b0; RESET_N = 1'b1;
    next_cycle;

    // Scan-only read at 0x00010
    scan_req = 1'b1; scan_addr = 19'h00010;
    mid;
    check_eq("scan_rd_gnt", 32'(scan_gnt), 32'd1);
    check_eq("scan_rd_dgnt", 32'(draw_gnt), 32'd0);
    next_cycle; scan_req = 1'b0;
    mid;
    check_eq("scan_rd_mem_en", 32'(mem_en), 32'd1);
    check_eq("scan_rd_mem_addr", 32'(mem_addr), 32'h00010);
    check_eq("scan_rd_mem_we", 32'(mem_we), 32'd0);
    check_eq("scan_rd_early_rv", 32'(scan_rvalid), 32'd0);
    next_cycle; mid;
    check_eq("scan_rd_rvalid", 32'(scan_rvalid), 32'd1);
    check_eq("scan_rd_rdata", 32'(scan_rdata), 32'h5A);
    check_eq("scan_rd_no_drv", 32'(draw_rvalid), 32'd0);
    next_cycle; mid;
    check_eq("scan_rd_rv_off", 32'(scan_rvalid), 32'd0);
    check_eq("scan_rd_hold", 32'(scan_rdata), 32'h5A);
    check_eq("idle_mem_en", 32'(mem_en), 32'd0);

    // Draw write at 0x4AFFF
    next_cycle;
    draw_req = 1'b1; draw_we = 1'b1; draw_addr = 19'h4AFFF; draw_wdata = 8'hC3;
    mid;
    check_eq("wr_gnt", 32'(draw_gnt), 32'd1);
    check_eq("wr_sgnt", 32'(scan_gnt), 32'd0);
    next_cycle; draw_req = 1'b0; draw_we = 1'b0;
    mid;
    check_eq("wr_mem_en", 32'(mem_en), 32'd1);
    check_eq("wr_mem_we", 32'(mem_we), 32'd1);
    check_eq("wr_mem_addr", 32'(mem_addr), 32'h4AFFF);
    check_eq("wr_mem_wdata", 32'(mem_wdata), 32'hC3);
    next_cycle; mid;
    check_eq("wr_no_rv1", 32'(draw_rvalid), 32'd0);
    check_eq("wr_mem_we_off", 32'(mem_we), 32'd0);
    next_cycle; mid;
    check_eq("wr_no_rv2", 32'(draw_rvalid), 32'd0);

    // Alternating owners: scan@0x123 then draw@0x456
    next_cycle;
    scan_req = 1'b1; scan_addr = 19'h00123;
    mid;
    check_eq("alt_sgnt", 32'(scan_gnt), 32'd1);
    next_cycle;
    scan_req = 1'b0; draw_req = 1'b1; draw_we = 1'b0; draw_addr = 19'h00456;
    mid;
    check_eq("alt_dgnt", 32'(draw_gnt), 32'd1);
    check_eq("alt_srv_early", 32'(scan_rvalid), 32'd0);
    next_cycle; draw_req = 1'b0;
    mid;
    check_eq("alt_srv", 32'(scan_rvalid), 32'd1);
    check_eq("alt_sdata", 32'(scan_rdata), 32'h69);
    check_eq("alt_drv_early", 32'(draw_rvalid), 32'd0);
    next_cycle; mid;
    check_eq("alt_drv", 32'(draw_rvalid), 32'd1);
    check_eq("alt_ddata", 32'(draw_rdata), 32'h1C);
    check_eq("alt_srv_off", 32'(scan_rvalid), 32'd0);
    next_cycle; mid;
    check_eq("alt_drv_off", 32'(draw_rvalid), 32'd0);
    check_eq("alt_dhold", 32'(draw_rdata), 32'h1C);
    check_eq("alt_shold", 32'(scan_rdata), 32'h69);

    // Conflict outside vblank: forced draw at cycle 16, then again at 33
    next_cycle;
    scan_req = 1'b1; scan_addr = 19'h00777;
    draw_req = 1'b1; draw_we = 1'b0; draw_addr = 19'h00888;
    for (int c = 0; c <= 33; c++) begin
      mid;
      if (c <= 14 || (c >= 17 && c <= 31)) begin
        check_eq($sformatf("cf_sgnt_c%0d", c), 32'(scan_gnt), 32'd1);
        check_eq($sformatf("cf_dgnt_c%0d", c), 32'(draw_gnt), 32'd0);
      end else if (c == 15 || c == 32) begin
        check_eq($sformatf("cf_dgnt_c%0d", c), 32'(draw_gnt), 32'd0);
      end else begin
        check_eq($sformatf("cf_force_c%0d", c), 32'(draw_gnt), 32'd1);
        check_eq($sformatf("cf_force_s_c%0d", c), 32'(scan_gnt), 32'd0);
      end
      if (c == 17) begin
        check_eq("cf_mem_addr", 32'(mem_addr), 32'h00888);
        check_eq("cf_mem_we", 32'(mem_we), 32'd0);
      end
      if (c == 18) begin
        check_eq("cf_drv", 32'(draw_rvalid), 32'd1);
        check_eq("cf_ddata", 32'(draw_rdata), 32'hC2);
      end
      next_cycle;
    end
    scan_req = 1'b0; draw_req = 1'b0;
    repeat (3) next_cycle;

    // vblank: draw wins from the second vblank cycle; scan only when draw idles
    vblank = 1'b1; scan_req = 1'b1; draw_req = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c == 6) draw_req = 1'b0;
      if (c == 7) begin
        draw_req = 1'b1; vblank = 1'b0;
      end
      mid;
      if (c == 0 || c == 6 || c == 8) begin
        check_eq($sformatf("vb_sgnt_c%0d", c), 32'(scan_gnt), 32'd1);
        check_eq($sformatf("vb_dgnt0_c%0d", c), 32'(draw_gnt), 32'd0);
      end else begin
        check_eq($sformatf("vb_dgnt_c%0d", c), 32'(draw_gnt), 32'd1);
        check_eq($sformatf("vb_sgnt0_c%0d", c), 32'(scan_gnt), 32'd0);
      end
      next_cycle;
    end
    scan_req = 1'b0; draw_req = 1'b0;
    repeat (3) next_cycle;

    // Reset one cycle after a granted read: the read must never return
    scan_req = 1'b1; scan_addr = 19'h00010;
    mid;
    check_eq("rr_sgnt", 32'(scan_gnt), 32'd1);
    next_cycle;
    RESET_N = 1'b0; draw_req = 1'b1;
    mid;
    check_eq("rr_sgnt_in_rst", 32'(scan_gnt), 32'd0);
    check_eq("rr_dgnt_in_rst", 32'(draw_gnt), 32'd0);
    next_cycle;
    RESET_N = 1'b1; scan_req = 1'b0; draw_req = 1'b0;
    mid;
    check_eq("rr_srv", 32'(scan_rvalid), 32'd0);
    check_eq("rr_drv", 32'(draw_rvalid), 32'd0);
    check_eq("rr_mem_en", 32'(mem_en), 32'd0);
    check_eq("rr_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rr_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rr_sdata", 32'(scan_rdata), 32'd0);
    check_eq("rr_ddata", 32'(draw_rdata), 32'd0);
    next_cycle; mid;
    check_eq("rr_srv_late", 32'(scan_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19, framebuffer word-address width (640x480 = 307200 words).
REQ-002 SHALL have parameter DW, default 8, framebuffer data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, the starvation limit for draw, in cycles (range 1..255).
REQ-004 CLOCK_50  in  1  sole clock; all state updates on the rising edge.
REQ-005 RESET_N  in  1  synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
REQ-006 vblank  in  1  high during the vertical blanking interval.
REQ-007 scan_req  in  1  scanout read request; held until granted.
REQ-008 scan_addr  in  AW  scanout read address.
REQ-009 scan_gnt  out  1  scanout request accepted this cycle (combinational).
REQ-010 scan_rvalid  out  1  scan_rdata valid this cycle.
REQ-011 scan_rdata  out  DW  scanout read data.
REQ-012 draw_req  in  1  draw-side request; held until granted.
REQ-013 draw_we  in  1  1 = write, 0 = read.
REQ-014 draw_addr  in  AW  draw-side address.
REQ-015 draw_wdata  in  DW  draw-side write data.
REQ-016 draw_gnt  out  1  draw request accepted this cycle (combinational).
REQ-017 draw_rvalid  out  1  draw_rdata valid this cycle.
REQ-018 draw_rdata  out  DW  draw-side read data.
REQ-019 mem_en, mem_we  out  1 each  single-port SRAM enable and write strobe (registered).
REQ-020 mem_addr  out  AW;  mem_wdata  out  DW;  both registered.
REQ-021 mem_rdata  in  DW  SRAM read data, valid exactly 1 cycle after a cycle with mem_en=1 and mem_we=0.

Function
REQ-022 Handshake: a transfer occurs in a cycle where req=1 and gnt=1; at most one gnt SHALL be asserted per cycle; gnt=0 whenever the corresponding req=0.
REQ-023 Arbitration mode register states: SCAN_PRI, DRAW_PRI, FORCE_DRAW.
REQ-024 SCAN_PRI (vblank=0): scan wins any conflict; draw is granted only when scan_req=0.
REQ-025 DRAW_PRI (entered on the cycle after vblank is seen as 1): draw wins any conflict; scan is granted only when draw_req=0.
REQ-026 Starvation counter (8-bit): increments each cycle draw_req=1 and draw_gnt=0; clears on draw_gnt or draw_req=0; saturates at MAX_WAIT.
REQ-027 In SCAN_PRI, when the counter equals MAX_WAIT, the state SHALL move to FORCE_DRAW on the next edge.
REQ-028 FORCE_DRAW grants draw unconditionally for exactly one cycle, then returns to SCAN_PRI (or to DRAW_PRI if vblank=1).
REQ-029 Transition out of DRAW_PRI to SCAN_PRI occurs on the cycle after vblank is seen as 0; a pending FORCE_DRAW takes precedence over that transition.
REQ-030 SRAM issue: on the edge ending a granted cycle T, mem_en=1 and mem_addr/mem_we/mem_wdata SHALL take the winner's values during T+1; with no grant, mem_en=0 and mem_we=0.
REQ-031 Read return: a read granted in cycle T SHALL assert the owner's rvalid in cycle T+2, with rdata = mem_rdata; this is a fixed 2-cycle latency.
REQ-032 A 2-deep owner/read tag pipeline SHALL route returns so that back-to-back grants alternating owners each return to the correct port, in order.
REQ-033 Writes SHALL produce no rvalid.
REQ-034 Throughput: one grant per cycle is sustainable indefinitely.
REQ-035 The rdata outputs SHALL hold their last value when rvalid=0.

Reset
REQ-036 With RESET_N=0 at an edge, the following SHALL hold: state=SCAN_PRI, starvation counter=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, both rvalid=0, both rdata=0, tag pipeline cleared.
REQ-037 While RESET_N=0, scan_gnt and draw_gnt SHALL be 0.
REQ-038 In-flight reads at reset SHALL be discarded: no rvalid after reset release for reads issued before reset.

Verification
REQ-039 Scan-only read: scan_req=1, addr=0x00010, mem_rdata=0x5A at T+2 -> scan_gnt at T, mem_en/addr=0x00010 at T+1, scan_rvalid with 0x5A at T+2.
REQ-040 Conflict, vblank=0, MAX_WAIT=15: scan_req and draw_req both held high -> scan granted cycles 0..14, draw_gnt at cycle 16 (FORCE_DRAW), then scan resumes and the counter restarts.
REQ-041 vblank=1 with both requesting -> draw_gnt every cycle from the second cycle of vblank onward; scan_gnt=0 until draw_req drops.
REQ-042 Draw write: addr=0x4AFFF, wdata=0xC3, we=1 -> mem_we=1 with that address and data at T+1; no draw_rvalid.
REQ-043 Alternating reads scan@A, draw@B on consecutive cycles -> scan_rvalid then draw_rvalid on consecutive cycles, each with its own data.
REQ-044 Reset asserted one cycle after a granted read -> no rvalid ever produced for that read; all outputs at reset values (REQ-036) on the next cycle.
